// File: rtl/rgb_to_gray_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rgb_to_gray_if                                              |
// | Desc   : Byte-wide image RAM port bundle (master = RAM user)         |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface rgb_to_gray_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 20
);
  logic                  RAM_ren;
  logic                  RAM_wen;
  logic [BYTE_WIDTH-1:0] RAM_in;
  logic [BYTE_WIDTH-1:0] RAM_out;
  logic [ADDR_WIDTH-1:0] RAM_addr;

  modport master (
    output RAM_ren,
    output RAM_wen,
    output RAM_in,
    output RAM_addr,
    input  RAM_out
  );

  modport slave (
    input  RAM_ren,
    input  RAM_wen,
    input  RAM_in,
    input  RAM_addr,
    output RAM_out
  );
endinterface
`default_nettype wire

// File: rtl/rgb_to_gray.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rgb_to_gray                                                 |
// | Desc   : In-place BGR -> luma conversion of a 24-bit BMP pixel array |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module rgb_to_gray #(
  parameter int BYTE_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 20,
  parameter int BMP_HEADER_SIZE = 54,
  parameter int BMP_TOTAL_SIZE  = 54 + 3 * 64 * 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  rgb_to_gray_if.master ram,
  output logic          gray_done
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RD_B  = 4'd1;
  localparam logic [3:0] S_RD_G  = 4'd2;
  localparam logic [3:0] S_RD_R  = 4'd3;
  localparam logic [3:0] S_CAP_R = 4'd4;
  localparam logic [3:0] S_CALC  = 4'd5;
  localparam logic [3:0] S_WR_B  = 4'd6;
  localparam logic [3:0] S_WR_G  = 4'd7;
  localparam logic [3:0] S_WR_R  = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  localparam logic [ADDR_WIDTH-1:0] C_BASE_RST = ADDR_WIDTH'(BMP_HEADER_SIZE);

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            b_q, g_q, r_q, gray_q;
  logic [15:0]           luma_sum;
  logic                  last_pixel;
  logic                  ren, wen;
  logic [7:0]            wdata;
  logic [1:0]            offset;

  // Stop once another full pixel would run past the end of the file.
  assign last_pixel = (32'(base_q) + 32'd6) > 32'(BMP_TOTAL_SIZE);

  // Weights sum to 256, so the 16-bit sum never overflows.
  assign luma_sum = (16'd77  * {8'd0, r_q})
                  + (16'd150 * {8'd0, g_q})
                  + (16'd29  * {8'd0, b_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= C_BASE_RST;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE:  if (in_valid && !gray_done) state_d = S_RD_B;
      S_RD_B:  state_d = S_RD_G;
      S_RD_G:  state_d = S_RD_R;
      S_RD_R:  state_d = S_CAP_R;
      S_CAP_R: state_d = S_CALC;
      S_CALC:  state_d = S_WR_B;
      S_WR_B:  state_d = S_WR_G;
      S_WR_G:  state_d = S_WR_R;
      S_WR_R: begin
        if (last_pixel) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD_B;
          base_d  = base_q + ADDR_WIDTH'(3);
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ren       = 1'b0;
    wen       = 1'b0;
    wdata     = 8'd0;
    offset    = 2'd0;
    gray_done = 1'b0;
    unique case (state_q)
      S_RD_B:  ren = 1'b1;
      S_RD_G:  begin ren = 1'b1; offset = 2'd1; end
      S_RD_R:  begin ren = 1'b1; offset = 2'd2; end
      S_WR_B:  begin wen = 1'b1; wdata = gray_q; end
      S_WR_G:  begin wen = 1'b1; wdata = gray_q; offset = 2'd1; end
      S_WR_R:  begin wen = 1'b1; wdata = gray_q; offset = 2'd2; end
      S_DONE:  gray_done = 1'b1;
      default: ;
    endcase
  end

  // Read data arrives one cycle after the address, hence the skewed captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= 8'd0;
      g_q    <= 8'd0;
      r_q    <= 8'd0;
      gray_q <= 8'd0;
    end else begin
      unique case (state_q)
        S_RD_G:  b_q    <= ram.RAM_out[7:0];
        S_RD_R:  g_q    <= ram.RAM_out[7:0];
        S_CAP_R: r_q    <= ram.RAM_out[7:0];
        S_CALC:  gray_q <= luma_sum[15:8];
        default: ;
      endcase
    end
  end

  assign ram.RAM_ren  = ren;
  assign ram.RAM_wen  = wen;
  assign ram.RAM_in   = BYTE_WIDTH'(wdata);
  assign ram.RAM_addr = base_q + ADDR_WIDTH'(offset);

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_gray.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_rgb_to_gray                                              |
// | Desc   : Scoreboard bench for rgb_to_gray with a behavioural RAM     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_rgb_to_gray;

  localparam int BW    = 8;
  localparam int AW    = 20;
  localparam int HDR   = 54;
  localparam int TOTAL = HDR + 20;            // 6 pixels plus 2 trailing bytes
  localparam int NPIX  = (TOTAL - HDR) / 3;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic in_valid = 1'b0;
  logic gray_done;
  logic load     = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] mem  [TOTAL];
  logic [7:0] img  [TOTAL];
  logic [7:0] gold [TOTAL];

  int  cyc      = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  acc_cnt  = 0;
  int  wr_cnt   = 0;
  int  first_rd = -1;
  int  done_cyc = -1;
  wr_t exp_q[$];

  rgb_to_gray_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) ram_bus ();

  rgb_to_gray #(
    .BYTE_WIDTH      (BW),
    .ADDR_WIDTH      (AW),
    .BMP_HEADER_SIZE (HDR),
    .BMP_TOTAL_SIZE  (TOTAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ram       (ram_bus),
    .gray_done (gray_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ram_bus.RAM_out = rdata;

  always @(posedge clk) begin
    if (load) begin
      mem <= img;
    end else begin
      if (ram_bus.RAM_wen && int'(ram_bus.RAM_addr) < TOTAL)
        mem[int'(ram_bus.RAM_addr)] <= ram_bus.RAM_in;
      if (ram_bus.RAM_ren && int'(ram_bus.RAM_addr) < TOTAL)
        rdata <= mem[int'(ram_bus.RAM_addr)];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_gray(input int b, input int g, input int r);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  // Monitor: protocol checks and scoreboard pops on every write.
  always @(negedge clk) begin
    int  a;
    wr_t e;
    a = int'(ram_bus.RAM_addr);
    if (rst_n) begin
      if (ram_bus.RAM_ren || ram_bus.RAM_wen) begin
        acc_cnt++;
        chk("ren_wen_exclusive", longint'(ram_bus.RAM_ren && ram_bus.RAM_wen), 0);
        chk("addr_in_pixel_array", longint'(a >= HDR && a < HDR + 3 * NPIX), 1);
      end
      if (ram_bus.RAM_ren && first_rd < 0) first_rd = cyc;
      if (gray_done && done_cyc < 0) done_cyc = cyc;
      if (ram_bus.RAM_wen) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", a, -1);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", a, e.addr);
          chk("write_data", longint'(ram_bus.RAM_in), e.data);
        end
      end
    end
  end

  task automatic build_expected();
    for (int i = 0; i < TOTAL; i++) gold[i] = mem[i];
    for (int p = 0; p < NPIX; p++) begin
      int a;
      int y;
      a = HDR + 3 * p;
      y = ref_gray(int'(gold[a]), int'(gold[a+1]), int'(gold[a+2]));
      for (int k = 0; k < 3; k++) begin
        exp_q.push_back('{addr: a + k, data: y});
        gold[a+k] = 8'(y);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ren"},  longint'(ram_bus.RAM_ren), 0);
    chk({tag, "_wen"},  longint'(ram_bus.RAM_wen), 0);
    chk({tag, "_in"},   longint'(ram_bus.RAM_in), 0);
    chk({tag, "_addr"}, longint'(ram_bus.RAM_addr), HDR);
    chk({tag, "_done"}, longint'(gray_done), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) img[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_pass(input bit hold);
    int s;
    int wr0;
    int bad;
    build_expected();
    first_rd = -1;
    done_cyc = -1;
    wr0      = wr_cnt;
    @(posedge clk); #1;
    s        = cyc;
    in_valid = 1'b1;
    if (!hold) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    for (int i = 0; i < 8 * NPIX + 20 && done_cyc < 0; i++) @(negedge clk);
    chk("done_seen", longint'(done_cyc >= 0), 1);
    chk("start_latency", first_rd, s + 1);
    chk("pass_latency", done_cyc - first_rd, 8 * NPIX);
    chk("write_count", wr_cnt - wr0, 3 * NPIX);
    chk("queue_drained", exp_q.size(), 0);
    // Further start requests after completion must not trigger another pass.
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (hold ? 20 : 1) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_rewrite_after_done", wr_cnt - wr0, 3 * NPIX);
    chk("done_sticky", longint'(gray_done), 1);
    bad = 0;
    for (int i = 0; i < TOTAL; i++) if (mem[i] !== gold[i]) bad++;
    chk("final_image_bad_bytes", bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  a0;
    int  wr0;
    bit  found;

    // Power-on: load an image whose first pixel is B,G,R = 0x10,0x20,0x30.
    fill_random();
    img[HDR] = 8'h10; img[HDR+1] = 8'h20; img[HDR+2] = 8'h30;
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    a0 = acc_cnt;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_no_access", acc_cnt - a0, 0);
    chk("idle_not_done", longint'(gray_done), 0);

    do_pass(1'b0);
    chk("px0_b", longint'(mem[HDR]),   8'h23);
    chk("px0_g", longint'(mem[HDR+1]), 8'h23);
    chk("px0_r", longint'(mem[HDR+2]), 8'h23);

    // Extremes with in_valid held high across the whole pass.
    fill_random();
    for (int k = 0; k < 3; k++) begin
      img[HDR+k]   = 8'hFF;
      img[HDR+3+k] = 8'h00;
    end
    img[HDR+6] = 8'h00; img[HDR+7]  = 8'h00; img[HDR+8]  = 8'hFF;
    img[HDR+9] = 8'h00; img[HDR+10] = 8'hFF; img[HDR+11] = 8'h00;
    do_reset();
    do_pass(1'b1);
    chk("white",  longint'(mem[HDR]),    8'hFF);
    chk("black",  longint'(mem[HDR+4]),  8'h00);
    chk("r_only", longint'(mem[HDR+8]),  8'h4C);
    chk("g_only", longint'(mem[HDR+9]),  8'h95);

    // Reset while the G byte of the second pixel is being written.
    fill_random();
    do_reset();
    build_expected();
    wr0 = wr_cnt;
    @(posedge clk); #1 in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (wr_cnt - wr0 == 5) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_px1_wr_g", longint'(found), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    do_pass(1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      do_reset();
      do_pass(r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_to_gray.md
# rgb_to_gray

In-place BGR-to-grayscale conversion stage for 24-bit BMP images held in the shared byte-wide image RAM. On start it walks the pixel array after the BMP header, three bytes (B, G, R) per pixel, and computes a weighted luma value. It writes that value back over all three bytes of the pixel. It asserts `gray_done` when the whole array is converted. It sits directly upstream of the binarization stage, which waits on `gray_done` before thresholding the same RAM region.

## Interface
- `BYTE_WIDTH`, default 8: RAM data width.
- `ADDR_WIDTH`, default 20: RAM address width.
- `BMP_HEADER_SIZE`, default 54: byte address of the first pixel byte.
- `BMP_TOTAL_SIZE`, default 54+3*64*64: total file size in bytes. The pixel array occupies addresses `BMP_HEADER_SIZE` to `BMP_TOTAL_SIZE-1`.
- `clk`, input, 1: clock, rising-edge active.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: start request, sampled in IDLE only.
- `RAM_out`, input, `BYTE_WIDTH`: RAM read data. It is valid the cycle after a read is issued.
- `RAM_ren`, output, 1: read enable.
- `RAM_wen`, output, 1: write enable. The RAM writes `RAM_in` to `RAM_addr` at the rising edge.
- `RAM_in`, output, `BYTE_WIDTH`: write data.
- `RAM_addr`, output, `ADDR_WIDTH`: RAM address.
- `gray_done`, output, 1: conversion complete. Sticky until reset.

## Operation
- Registers:
  - `base`: current pixel address.
  - `b_reg`, `g_reg`, `r_reg`: 8-bit captured channel bytes.
  - `gray_reg`: 8-bit result.
  - `state`: FSM state.
- FSM states and transitions:
  - IDLE goes to RD_B when `in_valid && !gray_done`.
  - RD_B → RD_G → RD_R → CAP_R → CALC → WR_B → WR_G → WR_R.
  - WR_R goes to DONE if `base+6 > BMP_TOTAL_SIZE`, else to RD_B with `base <= base+3`.
  - DONE holds until reset.
- Per-state outputs (`RAM_addr` is combinational, equal to `base` plus the offset below):
  - RD_B: `ren=1`, offset 0.
  - RD_G: `ren=1`, offset 1; capture `b_reg<=RAM_out`.
  - RD_R: `ren=1`, offset 2; capture `g_reg<=RAM_out`.
  - CAP_R: `ren=0`; capture `r_reg<=RAM_out`.
  - CALC: `gray_reg <= (77*r_reg + 150*g_reg + 29*b_reg) >> 8`.
  - WR_B, WR_G, WR_R: `wen=1`, `RAM_in=gray_reg`, offsets 0, 1, 2 respectively.
  - IDLE, CAP_R, CALC, DONE: offset 0.
- In all states other than those listed above, `ren=0`, `wen=0` and `RAM_in=0`.
- `ren` and `wen` are never both 1.
- Arithmetic:
  - Products are unsigned, and the sum is 16 bits wide.
  - Weights total 256, so the maximum sum is 65280 and the result is always 0..255 with no saturation needed.
  - The shift truncates; there is no rounding.
- Pixel count is `floor((BMP_TOTAL_SIZE-BMP_HEADER_SIZE)/3)`.
  - Trailing remainder bytes (1 or 2) are never read or written.
  - Row padding bytes inside the array are processed as ordinary pixel data. Image widths used with this block have no padding (3*width is a multiple of 4).
- If the pixel count is 0, IDLE+`in_valid` goes to RD_B, the block converts nothing useful, and it must not write outside the array. Parameter sets with fewer than 3 pixel bytes are unsupported.
- `in_valid` deasserting mid-conversion is ignored; the operation runs to completion.
- `in_valid` while `gray_done=1` is ignored.
- Reset mid-operation:
  - Forces IDLE and `base=BMP_HEADER_SIZE`.
  - Forces all outputs to their reset values immediately (asynchronously).
  - A partially written pixel is not repaired; the next start reconverts from the first pixel.

## Timing
- Reset values: `RAM_ren=0`, `RAM_wen=0`, `RAM_in=0`, `RAM_addr=BMP_HEADER_SIZE`, `gray_done=0`, state IDLE.
- Pixel cost is 8 cycles, from RD_B to WR_R inclusive.
- Start: `in_valid` sampled high in IDLE at edge k puts RD_B in the cycle after edge k.
- Total latency for N pixels: 8N cycles from the first RD_B to the last WR_R.
- `gray_done` rises in the cycle after the last WR_R, i.e. the first DONE cycle.
- The last write commits at the edge that enters DONE, so downstream may read the RAM as soon as it sees `gray_done=1`.
- Read latency is exactly 1 cycle. Data for an address presented in cycle t is captured at the end of cycle t+1.

## Test plan
- Single pixel (TOTAL=57), RAM[54..56]=0x10,0x20,0x30 (B,G,R), pulse `in_valid` → RAM[54..56]=0x23 each (8960>>8=35); `gray_done` rises 8 cycles after RD_B; no access outside 54..56.
- Extremes over 4 pixels (TOTAL=66): pixels (255,255,255), (0,0,0), R-only 255, G-only 255 → results 0xFF, 0x00, 0x4C (76), 0x95 (149); done after 32 cycles.
- Remainder (TOTAL=61, 7 pixel bytes) → two pixels converted; RAM[60] unchanged; no access to address 60.
- Reset mid-operation: assert `rst_n=0` during WR_G of pixel 2 → outputs return to their reset values within the same cycle. Then restart → all pixels converted from address 54; final RAM correct; `gray_done` after the full 8N cycles.
- Handshake: `in_valid` held high through completion, then pulsed again while DONE → exactly one conversion pass (no writes after DONE); `gray_done` stays 1. With `in_valid` never asserted → no RAM access for 100 cycles.
- Protocol check every cycle: never `ren&&wen`; `RAM_addr` always within [HEADER, TOTAL-1] whenever `ren` or `wen` is high.
